// File: rtl/note_scheduler.sv
// -----------------------------------------------------------------------------
// note_scheduler
//
// Walks one song of the song ROM word by word and presents each word to the
// sample generator's load interface. Note words go out back-to-back, at three
// cycles per word (FETCH, DECODE, LOAD). An advance word is loaded and then
// the scheduler holds until the generator reports that the advance duration
// has elapsed. The end-of-song marker, or running off the end of the song
// window, parks the block in DONE.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   play_enable  1 = run, 0 = freeze state and all registers
//   new_song     1-cycle pulse: restart at word 0 of song_select
//   song_select  song to start, sampled on new_song
//   rom_addr     registered ROM address {song, index}
//   rom_data     ROM word, valid one cycle after rom_addr changes
//   voices_full  no free voice: note words wait in DECODE
//   advance      advance duration reached (from the sample generator)
//   note         rom_data[14:9] of the last captured word
//   duration     rom_data[8:3]  of the last captured word
//   meta         rom_data[2:0]  of the last captured word
//   type_signal  rom_data[15]: 0 = note, 1 = advance
//   load_count   1-cycle strobe, fields valid while high
//   song_done    high in DONE
//   busy         high in every state except IDLE and DONE
// -----------------------------------------------------------------------------
module note_scheduler #(
   parameter int SONG_BITS = 2,
   parameter int IDX_BITS  = 7
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          play_enable,
   input  logic                          new_song,
   input  logic [SONG_BITS-1:0]          song_select,
   output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
   input  logic [15:0]                   rom_data,
   input  logic                          voices_full,
   input  logic                          advance,
   output logic [5:0]                    note,
   output logic [5:0]                    duration,
   output logic [2:0]                    meta,
   output logic                          type_signal,
   output logic                          load_count,
   output logic                          song_done,
   output logic                          busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_LOAD     = 3'd3,
      ST_WAIT_ADV = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam logic [IDX_BITS-1:0] IDX_LAST = {IDX_BITS{1'b1}};
   localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
   localparam logic [15:0]         END_WORD = 16'h8000;

   state_t                          state_r, state_s;
   logic [SONG_BITS-1:0]            song_r, song_s;
   logic [IDX_BITS-1:0]             idx_r, idx_s;
   logic [SONG_BITS+IDX_BITS-1:0]   rom_addr_r;
   logic [5:0]                      note_r, duration_r;
   logic [2:0]                      meta_r;
   logic                            type_r;
   logic                            load_r, load_s;
   logic                            done_r, done_s;
   logic                            busy_r, busy_s;
   logic                            capture_s;

   // Next-state, index and field-capture decisions.
   always_comb begin
      state_s   = state_r;
      song_s    = song_r;
      idx_s     = idx_r;
      capture_s = 1'b0;

      if (new_song) begin
         // Restart wins over every state and over play_enable.
         song_s  = song_select;
         idx_s   = {IDX_BITS{1'b0}};
         state_s = ST_FETCH;
      end else if (play_enable) begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_FETCH: begin
               state_s = ST_DECODE;
            end
            ST_DECODE: begin
               if (rom_data == END_WORD) begin
                  state_s = ST_DONE;
               end else begin
                  // rom_addr does not move while stalled, so re-capturing
                  // every cycle keeps the same word on the fields.
                  capture_s = 1'b1;
                  if (!rom_data[15] && voices_full) begin
                     state_s = ST_DECODE;
                  end else begin
                     state_s = ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (type_r) begin
                  state_s = ST_WAIT_ADV;
               end else if (idx_r == IDX_LAST) begin
                  // Off the end of the song window: finish, address kept.
                  state_s = ST_DONE;
               end else begin
                  idx_s   = idx_r + IDX_ONE;
                  state_s = ST_FETCH;
               end
            end
            ST_WAIT_ADV: begin
               if (!advance) begin
                  state_s = ST_WAIT_ADV;
               end else if (idx_r == IDX_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  idx_s   = idx_r + IDX_ONE;
                  state_s = ST_FETCH;
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end

      // Strobe only on entry to LOAD, so a pause inside LOAD never repeats it.
      load_s = (state_s == ST_LOAD) && (state_r != ST_LOAD);
      done_s = (state_s == ST_DONE);
      busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
   end

   // State, address and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         song_r     <= {SONG_BITS{1'b0}};
         idx_r      <= {IDX_BITS{1'b0}};
         rom_addr_r <= {(SONG_BITS+IDX_BITS){1'b0}};
         load_r     <= 1'b0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         song_r     <= song_s;
         idx_r      <= idx_s;
         rom_addr_r <= {song_s, idx_s};
         load_r     <= load_s;
         done_r     <= done_s;
         busy_r     <= busy_s;
      end
   end

   // Field registers: hold the last captured word between loads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         note_r     <= 6'd0;
         duration_r <= 6'd0;
         meta_r     <= 3'd0;
         type_r     <= 1'b0;
      end else if (capture_s) begin
         note_r     <= rom_data[14:9];
         duration_r <= rom_data[8:3];
         meta_r     <= rom_data[2:0];
         type_r     <= rom_data[15];
      end else begin
         note_r     <= note_r;
         duration_r <= duration_r;
         meta_r     <= meta_r;
         type_r     <= type_r;
      end
   end

   assign rom_addr    = rom_addr_r;
   assign note        = note_r;
   assign duration    = duration_r;
   assign meta        = meta_r;
   assign type_signal = type_r;
   assign load_count  = load_r;
   assign song_done   = done_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler. Cycle numbering in the sequences counts
// the cycle in which new_song is high as cycle 1.
module tb_note_scheduler;

   logic        clk;
   logic        reset;
   logic        play_enable;
   logic        new_song;
   logic [1:0]  song_select;
   logic [8:0]  rom_addr;
   logic [15:0] rom_data;
   logic        voices_full;
   logic        advance;
   logic [5:0]  note;
   logic [5:0]  duration;
   logic [2:0]  meta;
   logic        type_signal;
   logic        load_count;
   logic        song_done;
   logic        busy;

   logic [15:0] rom [0:511];

   int errors;
   int checks;

   typedef struct {
      logic [15:0] word;
      logic [5:0]  note;
      logic [5:0]  dur;
      logic [2:0]  meta;
      logic        typ;
   } vec_t;

   vec_t vecs [8];

   note_scheduler #(.SONG_BITS(2), .IDX_BITS(7)) dut (
      .clk         (clk),
      .reset       (reset),
      .play_enable (play_enable),
      .new_song    (new_song),
      .song_select (song_select),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .voices_full (voices_full),
      .advance     (advance),
      .note        (note),
      .duration    (duration),
      .meta        (meta),
      .type_signal (type_signal),
      .load_count  (load_count),
      .song_done   (song_done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data one cycle after the address.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pulse new_song; returns in cycle 2 (FETCH).
   task automatic pulse_song(input logic [1:0] s);
      new_song    = 1'b1;
      song_select = s;
      step();
      new_song    = 1'b0;
   endtask

   initial begin
      int loads;
      int moved;
      logic [5:0] last_note;
      logic [5:0] n6;

      errors = 0;
      checks = 0;
      vecs[0] = '{16'h1234, 6'h09, 6'h06, 3'd4, 1'b0};
      vecs[1] = '{16'h2468, 6'h12, 6'h0D, 3'd0, 1'b0};
      vecs[2] = '{16'h8018, 6'h00, 6'h03, 3'd0, 1'b1};
      vecs[3] = '{16'hFFFF, 6'h3F, 6'h3F, 3'd7, 1'b1};
      vecs[4] = '{16'h7FFF, 6'h3F, 6'h3F, 3'd7, 1'b0};
      vecs[5] = '{16'h0001, 6'h00, 6'h00, 3'd1, 1'b0};
      vecs[6] = '{16'h4A55, 6'h25, 6'h0A, 3'd5, 1'b0};
      vecs[7] = '{16'h83C2, 6'h01, 6'h38, 3'd2, 1'b1};

      for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
      rom[9'h080] = 16'h1234; rom[9'h081] = 16'h2468; rom[9'h082] = 16'h8000;
      rom[9'h100] = 16'h8018; rom[9'h101] = 16'h1234; rom[9'h102] = 16'h8000;
      rom[9'h000] = 16'h2468; rom[9'h001] = 16'h8000;

      reset = 1'b0; play_enable = 1'b1; new_song = 1'b0; song_select = 2'd0;
      voices_full = 1'b0; advance = 1'b0;

      // Reset state
      #1;
      chk("rst_load", {31'd0, load_count}, 32'd0);
      chk("rst_addr", {23'd0, rom_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, song_done}, 32'd0);
      chk("rst_fields", {16'd0, note, duration, meta, type_signal}, 32'd0);
      step(); step();
      reset = 1'b1;
      step(); step(); step();
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_addr", {23'd0, rom_addr}, 32'd0);

      // Note sequence, song 1: loads on cycles 4 and 7
      pulse_song(2'd1);
      chk("ns_addr", {23'd0, rom_addr}, 32'h080);
      for (int c = 2; c <= 12; c++) begin
         chk($sformatf("ns_load_c%0d", c), {31'd0, load_count},
             ((c == 4) || (c == 7)) ? 32'd1 : 32'd0);
         if (c == 4) chk("ns_f1", {17'd0, note, duration, meta}, {17'd0, 6'h09, 6'h06, 3'd4});
         if (c == 5) chk("ns_busy", {31'd0, busy}, 32'd1);
         if (c == 7) chk("ns_f2", {17'd0, note, duration, meta}, {17'd0, 6'h12, 6'h0D, 3'd0});
         if (c < 12) step();
      end
      chk("ns_done", {31'd0, song_done}, 32'd1);
      chk("ns_busy_end", {31'd0, busy}, 32'd0);
      chk("ns_addr_end", {23'd0, rom_addr}, 32'h082);

      // Advance wait, song 2
      pulse_song(2'd2);
      step(); step();
      chk("adv_load", {31'd0, load_count}, 32'd1);
      chk("adv_type", {31'd0, type_signal}, 32'd1);
      chk("adv_dur", {26'd0, duration}, 32'd3);
      advance = 1'b1;          // during LOAD: must be ignored
      step();
      advance = 1'b0;
      loads = 0; moved = 0;
      for (int i = 0; i < 50; i++) begin
         if (load_count) loads++;
         if (rom_addr != 9'h100) moved++;
         step();
      end
      chk("adv_no_load", loads, 32'd0);
      chk("adv_no_fetch", moved, 32'd0);
      advance = 1'b1;
      step();
      advance = 1'b0;
      chk("adv_addr_inc", {23'd0, rom_addr}, 32'h101);
      chk("adv_load_after", {31'd0, load_count}, 32'd0);
      step(); step();
      chk("adv_next_load", {31'd0, load_count}, 32'd1);
      chk("adv_next_note", {26'd0, note}, 32'h09);
      chk("adv_next_type", {31'd0, type_signal}, 32'd0);

      // Voice stall, song 0
      voices_full = 1'b1;
      pulse_song(2'd0);
      step();
      loads = 0;
      for (int i = 0; i < 20; i++) begin
         if (load_count) loads++;
         step();
      end
      chk("stall_no_load", loads, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      voices_full = 1'b0;
      step();
      chk("stall_load", {31'd0, load_count}, 32'd1);
      chk("stall_note", {26'd0, note}, 32'h12);

      // Field decode table, song 3
      for (int v = 0; v < 8; v++) begin
         rom[9'h180] = vecs[v].word;
         rom[9'h181] = 16'h8000;
         pulse_song(2'd3);
         chk($sformatf("tbl%0d_addr", v), {23'd0, rom_addr}, 32'h180);
         step();
         chk($sformatf("tbl%0d_early", v), {31'd0, load_count}, 32'd0);
         step();
         chk($sformatf("tbl%0d_load", v), {31'd0, load_count}, 32'd1);
         chk($sformatf("tbl%0d_fields", v), {16'd0, note, duration, meta, type_signal},
             {16'd0, vecs[v].note, vecs[v].dur, vecs[v].meta, vecs[v].typ});
      end

      // Pause in WAIT_ADV, song 3
      rom[9'h180] = 16'h8018;
      rom[9'h181] = 16'h8000;
      pulse_song(2'd3);
      step(); step(); step();
      play_enable = 1'b0;
      advance = 1'b1;
      step();
      advance = 1'b0;
      step(); step(); step();
      chk("pause_addr", {23'd0, rom_addr}, 32'h180);
      chk("pause_load", {31'd0, load_count}, 32'd0);
      chk("pause_busy", {31'd0, busy}, 32'd1);
      play_enable = 1'b1;
      step(); step(); step();
      chk("resume_addr", {23'd0, rom_addr}, 32'h180);
      chk("resume_done", {31'd0, song_done}, 32'd0);

      // Restart into song 2 from WAIT_ADV, pulse while paused
      play_enable = 1'b0;
      pulse_song(2'd2);
      chk("rs_addr", {23'd0, rom_addr}, 32'h100);
      chk("rs_no_load", {31'd0, load_count}, 32'd0);
      chk("rs_busy", {31'd0, busy}, 32'd1);
      play_enable = 1'b1;
      step(); step();
      chk("rs_load", {31'd0, load_count}, 32'd1);
      chk("rs_fields", {24'd0, duration, type_signal, 1'b0}, {24'd0, 6'd3, 1'b1, 1'b0});

      // Wrap: song 1 full of note words, no end marker
      for (int i = 0; i < 128; i++) begin
         n6 = i[5:0];
         rom[9'h080 + i] = {1'b0, n6, 9'd0};
      end
      pulse_song(2'd1);
      loads = 0; last_note = 6'd0;
      for (int i = 0; i < 600; i++) begin
         if (song_done) break;
         if (load_count) begin
            loads++;
            last_note = note;
         end
         step();
      end
      chk("wrap_loads", loads, 32'd128);
      chk("wrap_done", {31'd0, song_done}, 32'd1);
      chk("wrap_addr", {23'd0, rom_addr}, 32'h0FF);
      chk("wrap_last_note", {26'd0, last_note}, 32'h3F);
      chk("wrap_busy", {31'd0, busy}, 32'd0);

      // Async reset in the middle of LOAD
      pulse_song(2'd1);
      step(); step();
      chk("ar_load_pre", {31'd0, load_count}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("ar_load", {31'd0, load_count}, 32'd0);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_addr", {23'd0, rom_addr}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      loads = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (load_count || busy || song_done || (rom_addr != 9'd0)) loads++;
      end
      chk("ar_idle", loads, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequencer that walks a song ROM and feeds the sample generator's load interface (note, duration, meta, type_signal, load_count).
- Issues note words back-to-back, then holds on each advance word until the generator's advance fires.
- Sits between the song ROM and the sample generator. Reports end of song to the top-level control FSM.

Parameters:
- SONG_BITS, 2, width of the song select; the ROM holds 2^SONG_BITS songs.
- IDX_BITS, 7, width of the word index within a song; the ROM holds 2^IDX_BITS words per song.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play_enable  in  1  1 = run; 0 = freeze the FSM in place
- new_song  in  1  1-cycle pulse; (re)start at index 0 of song_select
- song_select  in  SONG_BITS  song to start; sampled on new_song
- rom_addr  out  SONG_BITS+IDX_BITS  registered address {song, index}
- rom_data  in  16  ROM word; valid 1 cycle after rom_addr changes
- voices_full  in  1  1 = no free note_player voice
- advance  in  1  from the sample generator: advance duration reached
- note  out  6  registered, rom_data[14:9]
- duration  out  6  registered, rom_data[8:3]
- meta  out  3  registered, rom_data[2:0]
- type_signal  out  1  registered, rom_data[15]; 0 = note, 1 = advance
- load_count  out  1  1-cycle strobe; the five fields above are valid while it is high
- song_done  out  1  high in DONE
- busy  out  1  high in any state except IDLE and DONE

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; rom_addr = 0.
  - State IDLE; latched song = 0; index = 0.
- States: IDLE, FETCH, DECODE, LOAD, WAIT_ADV, DONE.
- IDLE: stays in IDLE until new_song.
- new_song, in any state, has priority over everything else:
  - latch song_select; index = 0; rom_addr = {song_select, 0}; next state FETCH.
  - load_count stays 0 that cycle.
  - The new_song restart applies even when play_enable = 0.
- FETCH: rom_addr is stable for one cycle; next state DECODE.
- DECODE: capture rom_data.
  - If the word is 16'h8000 (end marker), go to DONE.
  - Otherwise register the fields onto note/duration/meta/type_signal.
  - Go to LOAD, except when type_signal = 0 and voices_full = 1: stay in DECODE with the word held, and re-check each cycle.
- LOAD:
  - Assert load_count for exactly 1 cycle.
  - If type = 0 (note): index + 1, go to FETCH.
  - If type = 1 (advance): go to WAIT_ADV.
- WAIT_ADV:
  - Sample advance from the cycle after load_count; advance in the LOAD cycle itself is ignored.
  - On advance = 1: index + 1, go to FETCH.
- Index wrap: incrementing from index = 2^IDX_BITS-1 goes to DONE instead of FETCH, and rom_addr is left unchanged.
- Fields keep their last loaded values between loads.
- play_enable = 0:
  - The FSM holds its state and all registers.
  - No load_count is issued.
  - advance is ignored.
  - On resume, the FSM continues from the same state.
- DONE: song_done = 1 and busy = 0. Stays in DONE until new_song.
- Throughput: 3 cycles per note word (FETCH, DECODE, LOAD) when there is no stall.
- An advance word costs 3 cycles plus the wait for advance.

Test Plan:
- Note sequence: new_song with song 1; ROM words 0x1234, 0x2468, 0x8000 -> load_count on cycles 4 and 7 after the pulse.
  - Load 1: note=0x09, duration=0x06, meta=4.
  - Load 2: note=0x12, duration=0x0D, meta=0.
  - Then song_done=1, busy=0, rom_addr=0x82.
- Advance wait: word 0x8018 (advance, duration 3); advance held 0 for 50 cycles, then pulsed -> exactly one load_count with type_signal=1 and duration=3; no fetch until advance; the next rom_addr increments one cycle after advance.
- Stall and pause:
  - voices_full=1 for 20 cycles while a note word is in DECODE -> no load_count; load_count fires 1 cycle after voices_full drops.
  - play_enable=0 in WAIT_ADV with advance pulsed -> ignored; the FSM stays in WAIT_ADV.
- Restart: new_song with song 2 while in WAIT_ADV -> rom_addr=0x100 next cycle; no load_count on the pulse cycle; the first load comes from word 0 of song 2.
- Wrap: a song with no end marker (all note words) -> 128 load_count pulses, then song_done=1 with rom_addr={song, 0x7F}.
- Async reset: reset=0 asserted mid-LOAD with no clock edge -> load_count, busy and rom_addr go to 0 immediately; after release the FSM stays in IDLE until new_song.
